// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way picker. A tie goes to the port that was not served last.
// With MEM_ARB_RR_EN undefined the top ties `last` to PORT_LOAD, which makes port 0 always win.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       win
);

    always_comb begin
        win = PORT_CORE;
        if (req[0] && req[1]) begin
            win = ~last;
        end else if (req[1]) begin
            win = PORT_LOAD;
        end
        gnt = 2'b00;
        if (|req) begin
            gnt[win] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one unified memory between the core (port 0) and a loader (port 1): accept, one access cycle, respond.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise fixed priority to port 0.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              win_q, win_d;

    logic [1:0] pick_gnt;
    logic       pick_win;
    logic       pick_last;
    logic       accept;

`ifdef MEM_ARB_RR_EN
    // rr_ptr_q names the port preferred on the next tie
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = ~pick_win;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= PORT_CORE;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign pick_last = ~rr_ptr_q;
`else
    assign pick_last = PORT_LOAD;
`endif

    arb_pick u_pick (
        .req  ({req1, req0}),
        .last (pick_last),
        .gnt  (pick_gnt),
        .win  (pick_win)
    );

    assign accept = (state_q != ACCESS) && (req0 || req1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            win_q   <= PORT_CORE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: state_d = accept ? ACCESS : IDLE;
            ACCESS:     state_d = RESP;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        win_d   = win_q;
        rdata_d = rdata_q;
        if (accept) begin
            win_d   = pick_win;
            addr_d  = (pick_win == PORT_LOAD) ? addr1  : addr0;
            wdata_d = (pick_win == PORT_LOAD) ? wdata1 : wdata0;
            we_d    = (pick_win == PORT_LOAD) ? we1    : we0;
        end
        if (state_q == ACCESS) begin
            rdata_d = mem_rd;
        end
    end

    // Handshake strobes are squashed while reset is high, even mid-access
    always_comb begin
        gnt0    = accept && pick_gnt[0] && !reset;
        gnt1    = accept && pick_gnt[1] && !reset;
        mem_we  = (state_q == ACCESS) && we_q && !reset;
        rvalid0 = (state_q == RESP) && (win_q == PORT_CORE) && !reset;
        rvalid1 = (state_q == RESP) && (win_q == PORT_LOAD) && !reset;
        mem_a   = addr_q;
        mem_wd  = wdata_q;
        rdata0  = rdata_q;
        rdata1  = rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-addressed memory model on the mem_* pins.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];
    logic        mem_init = 1'b0;
    logic        exp_g0, exp_g1;

    always #5 clk = ~clk;

    // Memory model: preloaded with word i = i * 0x11111111, written on the rising edge
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = i * 32'h1111_1111;
            mem_init = 1'b1;
        end
        if (mem_we) mem[mem_a[7:2]] = mem_wd;
    end
    assign mem_rd = mem[mem_a[7:2]];

    mem_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_we  (mem_we),
        .mem_rd  (mem_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        // Reset state
        step(); step();
        sample();
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        step(); reset = 1'b0;

        // Port 0 write 0xDEADBEEF to 0x10
        step(); req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
        sample();
        chk("wr_gnt0", {31'd0, gnt0}, 32'd1);
        chk("wr_gnt1", {31'd0, gnt1}, 32'd0);
        step(); req0 = 0; we0 = 0;
        sample();
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_a", mem_a, 32'h10);
        chk("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
        chk("wr_rvalid_early", {31'd0, rvalid0}, 32'd0);
        step();
        sample();
        chk("wr_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("wr_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("wr_mem_we_resp", {31'd0, mem_we}, 32'd0);
        chk("wr_mem_content", mem[4], 32'hDEAD_BEEF);

        // Port 1 reads back 0x10
        step(); req1 = 1; we1 = 0; addr1 = 32'h10;
        sample();
        chk("rd1_gnt1", {31'd0, gnt1}, 32'd1);
        step(); req1 = 0;
        sample();
        chk("rd1_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rd1_mem_a", mem_a, 32'h10);
        step();
        sample();
        chk("rd1_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("rd1_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rd1_rdata1", rdata1, 32'hDEAD_BEEF);

        // Both ports request reads continuously for four accesses
        step(); req0 = 1; we0 = 0; addr0 = 32'h10; req1 = 1; we1 = 0; addr1 = 32'h14;
        for (int k = 0; k < 4; k++) begin
            sample();
`ifdef MEM_ARB_RR_EN
            exp_g0 = (k % 2 == 0);
`else
            exp_g0 = 1'b1;
`endif
            exp_g1 = ~exp_g0;
            chk($sformatf("tie_gnt0_%0d", k), {31'd0, gnt0}, {31'd0, exp_g0});
            chk($sformatf("tie_gnt1_%0d", k), {31'd0, gnt1}, {31'd0, exp_g1});
            if (k == 3) begin
                step(); req0 = 0; req1 = 0;
            end else begin
                step();
                sample();
                chk($sformatf("tie_access_nognt_%0d", k), {30'd0, gnt1, gnt0}, 32'd0);
                step();
            end
        end
        step();
        sample();
`ifdef MEM_ARB_RR_EN
        chk("tie_last_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("tie_last_rdata", rdata1, 32'h5555_5555);
`else
        chk("tie_last_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("tie_last_rdata", rdata0, 32'hDEAD_BEEF);
`endif

        // Back-to-back: port 0 re-requests in its own RESP cycle
        step(); req0 = 1; we0 = 0; addr0 = 32'h10;
        sample();
        chk("b2b_gnt0_a", {31'd0, gnt0}, 32'd1);
        chk("b2b_rvalid0_a", {31'd0, rvalid0}, 32'd0);
        step(); req0 = 0;
        sample();
        chk("b2b_access_gnt0", {31'd0, gnt0}, 32'd0);
        step(); req0 = 1; addr0 = 32'h14;
        sample();
        chk("b2b_gnt0_b", {31'd0, gnt0}, 32'd1);
        chk("b2b_rvalid0_b", {31'd0, rvalid0}, 32'd1);
        chk("b2b_rdata0_b", rdata0, 32'hDEAD_BEEF);
        step(); req0 = 0;
        sample();
        chk("b2b_mem_a", mem_a, 32'h14);
        step();
        sample();
        chk("b2b_rvalid0_c", {31'd0, rvalid0}, 32'd1);
        chk("b2b_rdata0_c", rdata0, 32'h5555_5555);
        chk("b2b_gnt0_c", {31'd0, gnt0}, 32'd0);

        // Reset in the ACCESS cycle of a write of 0x55 to 0x20
        step(); req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h55;
        sample();
        chk("rstacc_gnt0", {31'd0, gnt0}, 32'd1);
        step(); req0 = 0; we0 = 0; reset = 1;
        sample();
        chk("rstacc_mem_we", {31'd0, mem_we}, 32'd0);
        step(); reset = 0;
        sample();
        chk("rstacc_rvalid_a", {30'd0, rvalid1, rvalid0}, 32'd0);
        step();
        sample();
        chk("rstacc_rvalid_b", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rstacc_mem_kept", mem[8], 32'h8888_8888);
        step(); req1 = 1; we1 = 0; addr1 = 32'h20;
        sample();
        chk("rstacc_rd_gnt1", {31'd0, gnt1}, 32'd1);
        step(); req1 = 0;
        step();
        sample();
        chk("rstacc_rd_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("rstacc_rd_rdata1", rdata1, 32'h8888_8888);

        // req1 pulsed for one cycle while port 0 owns ACCESS
        step(); req0 = 1; we0 = 0; addr0 = 32'h10;
        sample();
        chk("pulse_gnt0", {31'd0, gnt0}, 32'd1);
        step(); req0 = 0; req1 = 1; we1 = 1; addr1 = 32'h30; wdata1 = 32'hBAD;
        sample();
        chk("pulse_gnt1_access", {31'd0, gnt1}, 32'd0);
        step(); req1 = 0; we1 = 0;
        sample();
        chk("pulse_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("pulse_gnt1_resp", {31'd0, gnt1}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            step();
            sample();
            chk($sformatf("pulse_quiet_%0d", c), {29'd0, gnt1, rvalid1, mem_we}, 32'd0);
        end
        chk("pulse_mem_untouched", mem[12], 32'hCCCC_CCCC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
